// File: rtl/ucsbece154b_perf_pkg.sv
// Shared definitions for the pipeline performance monitor:
// counter indices, counter count and FSM state encoding.
package ucsbece154b_perf_pkg;

    localparam int NUM_CNT    = 7;
    localparam int CNT_CYCLES = 0;
    localparam int CNT_INSTR  = 1;
    localparam int CNT_BRANCH = 2;
    localparam int CNT_BR_MISS = 3;
    localparam int CNT_JUMP   = 4;
    localparam int CNT_J_MISS = 5;
    localparam int CNT_STALL  = 6;
    localparam int RD_OVF     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ucsbece154b_perf_ctr.sv
// One event counter with wrap or saturate behaviour and a sticky overflow flag.
module ucsbece154b_perf_ctr #(
    parameter int CNT_W    = 32,
    parameter int INC_W    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    // One extra bit catches the carry out of the counter.
    logic [CNT_W:0] sum;
    assign sum = {1'b0, count} + (CNT_W+1)'(inc);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            if (sum[CNT_W]) begin
                ovf   <= 1'b1;
                count <= (SATURATE != 0) ? '1 : sum[CNT_W-1:0];
            end else begin
                count <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// Performance monitor: per-lane event qualification, popcount increments,
// run/done FSM with idle-based end detection, snapshot bank and read port.
module ucsbece154b_perf_monitor
    import ucsbece154b_perf_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int CNT_W      = 32,
    parameter int SATURATE   = 0,
    parameter int IDLE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] valid_i,
    input  logic [LANES-1:0] is_branch_i,
    input  logic [LANES-1:0] is_jump_i,
    input  logic [LANES-1:0] mispredict_i,
    input  logic             stall_i,
    input  logic             done_i,
    input  logic             clear_i,
    input  logic             snapshot_i,
    input  logic [2:0]       rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [6:0]       ovf_o,
    output logic [1:0]       state_o,
    output logic             done_o
);

    localparam int INC_W = $clog2(LANES + 1);

    function automatic logic [INC_W-1:0] popcnt(input logic [LANES-1:0] v);
        popcnt = '0;
        for (int k = 0; k < LANES; k++) popcnt = popcnt + INC_W'(v[k]);
    endfunction

    state_t state, state_nxt;
    logic [7:0] idle_cnt;
    logic       any_valid, cnt_en, idle_hit;
    logic [LANES-1:0] br, jmp;
    logic [NUM_CNT-1:0][INC_W-1:0] inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [NUM_CNT-1:0][CNT_W-1:0] shadow;
    logic [NUM_CNT-1:0]            ovf;
    logic [CNT_W-1:0]              rd_mux;

    assign any_valid = |valid_i;
    // The IDLE->RUN cycle itself is counted, so enable covers it too.
    assign cnt_en    = (state == ST_RUN) || (state == ST_IDLE && any_valid);
    assign idle_hit  = !any_valid && ((idle_cnt + 8'd1) >= 8'(IDLE_LIMIT));

    assign br  = valid_i & is_branch_i;
    assign jmp = valid_i & is_jump_i & ~is_branch_i;

    assign inc[CNT_CYCLES]  = INC_W'(1);
    assign inc[CNT_INSTR]   = popcnt(valid_i);
    assign inc[CNT_BRANCH]  = popcnt(br);
    assign inc[CNT_BR_MISS] = popcnt(br & mispredict_i);
    assign inc[CNT_JUMP]    = popcnt(jmp);
    assign inc[CNT_J_MISS]  = popcnt(jmp & mispredict_i);
    assign inc[CNT_STALL]   = INC_W'(stall_i);

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_ctr
        ucsbece154b_perf_ctr #(
            .CNT_W    (CNT_W),
            .INC_W    (INC_W),
            .SATURATE (SATURATE)
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .clear (clear_i),
            .en    (cnt_en),
            .inc   (inc[g]),
            .count (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (any_valid) state_nxt = ST_RUN;
                ST_RUN:  if (done_i || idle_hit) state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) idle_cnt <= '0;
        else if (cnt_en)      idle_cnt <= any_valid ? 8'd0 : idle_cnt + 8'd1;
    end

    // Snapshot wins over clear so a simultaneous clear still captures pre-clear values.
    always_ff @(posedge clk) begin
        if (reset)           shadow <= '0;
        else if (snapshot_i) shadow <= cnt;
        else if (clear_i)    shadow <= '0;
    end

    always_comb begin
        rd_mux = '0;
        if (rd_sel_i == 3'(RD_OVF)) rd_mux = CNT_W'(ovf);
        for (int i = 0; i < NUM_CNT; i++)
            if (rd_sel_i == 3'(i)) rd_mux = shadow[i];
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_o <= '0;
        else       rd_data_o <= rd_mux;
    end

    assign ovf_o   = ovf;
    assign state_o = state;
    assign done_o  = (state == ST_DONE);

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Directed bench: three monitors share stimulus (default config, and 8-bit
// wrap/saturate configs with IDLE_LIMIT=4) and are checked against hand values.
module tb_ucsbece154b_perf_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] valid_i, is_branch_i, is_jump_i, mispredict_i;
    logic       stall_i, done_i, clear_i, snapshot_i;
    logic [2:0] rd_sel_i;

    logic [31:0] d0_rd;
    logic [7:0]  dw_rd, ds_rd;
    logic [6:0]  d0_ovf, dw_ovf, ds_ovf;
    logic [1:0]  d0_st, dw_st, ds_st;
    logic        d0_done, dw_done, ds_done;

    int n_chk = 0;
    int n_ok  = 0;

    always #5 clk = ~clk;

    ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(32), .SATURATE(0), .IDLE_LIMIT(16)) d0 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .is_branch_i(is_branch_i),
        .is_jump_i(is_jump_i), .mispredict_i(mispredict_i), .stall_i(stall_i),
        .done_i(done_i), .clear_i(clear_i), .snapshot_i(snapshot_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(d0_rd), .ovf_o(d0_ovf), .state_o(d0_st), .done_o(d0_done));

    ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(8), .SATURATE(0), .IDLE_LIMIT(4)) dw (
        .clk(clk), .reset(reset), .valid_i(valid_i), .is_branch_i(is_branch_i),
        .is_jump_i(is_jump_i), .mispredict_i(mispredict_i), .stall_i(stall_i),
        .done_i(done_i), .clear_i(clear_i), .snapshot_i(snapshot_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(dw_rd), .ovf_o(dw_ovf), .state_o(dw_st), .done_o(dw_done));

    ucsbece154b_perf_monitor #(.LANES(2), .CNT_W(8), .SATURATE(1), .IDLE_LIMIT(4)) ds (
        .clk(clk), .reset(reset), .valid_i(valid_i), .is_branch_i(is_branch_i),
        .is_jump_i(is_jump_i), .mispredict_i(mispredict_i), .stall_i(stall_i),
        .done_i(done_i), .clear_i(clear_i), .snapshot_i(snapshot_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(ds_rd), .ovf_o(ds_ovf), .state_o(ds_st), .done_o(ds_done));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] sel);
        rd_sel_i = sel;
        step();
    endtask

    task automatic snap();
        snapshot_i = 1'b1;
        step();
        snapshot_i = 1'b0;
    endtask

    task automatic clr();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_i = '0; is_branch_i = '0; is_jump_i = '0; mispredict_i = '0;
        stall_i = 0; done_i = 0; clear_i = 0; snapshot_i = 0; rd_sel_i = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_state", dw_st, 0);
        chk("rst_done", dw_done, 0);
        chk("rst_ovf", dw_ovf, 0);
        chk("rst_rd", d0_rd, 0);

        // basic run
        valid_i = 2'b11;
        repeat (10) step();
        snap();
        rd(0); chk("basic_cyc", d0_rd, 10); chk("basic_cyc_w", dw_rd, 10);
        rd(1); chk("basic_instr", d0_rd, 20);
        rd(7); chk("basic_ovf", d0_rd, 0);
        chk("basic_state", d0_st, 1);

        // branch statistics
        valid_i = 2'b00;
        clr();
        chk("clr_state", dw_st, 0);
        valid_i = 2'b11; is_branch_i = 2'b01; is_jump_i = 2'b10; mispredict_i = 2'b01;
        repeat (4) step();
        valid_i = 2'b01; is_branch_i = 2'b01; is_jump_i = 2'b01; mispredict_i = 2'b10; stall_i = 1;
        step();
        valid_i = 2'b11; is_branch_i = '0; is_jump_i = '0; mispredict_i = '0; stall_i = 0;
        snap();
        rd(0); chk("br_cyc", dw_rd, 5);
        rd(1); chk("br_instr", dw_rd, 9);
        rd(2); chk("br_branch", dw_rd, 5);
        rd(3); chk("br_brmiss", dw_rd, 4);
        rd(4); chk("br_jump", dw_rd, 4);
        rd(5); chk("br_jmiss", dw_rd, 0);
        rd(6); chk("br_stall", dw_rd, 1);

        // idle-based end of run
        valid_i = 2'b00;
        clr();
        valid_i = 2'b11;
        repeat (3) step();
        valid_i = 2'b00;
        repeat (3) step();
        chk("idle_still_run", dw_st, 1);
        step();
        chk("idle_done_state", dw_st, 2);
        chk("idle_done_o", dw_done, 1);
        chk("idle_d0_run", d0_st, 1);
        valid_i = 2'b11;
        repeat (3) step();
        chk("idle_hold", dw_st, 2);
        snap();
        rd(0); chk("idle_cyc", dw_rd, 7); chk("idle_d0_cyc", d0_rd, 10);
        rd(1); chk("idle_instr", dw_rd, 6);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        chk("ext_done_state", d0_st, 2);
        chk("ext_done_o", d0_done, 1);

        // overflow, wrap versus saturate
        clr();
        repeat (130) step();
        snap();
        rd(1); chk("ovf_wrap_instr", dw_rd, 4); chk("ovf_sat_instr", ds_rd, 255);
        rd(0); chk("ovf_cyc", dw_rd, 130);
        rd(7); chk("ovf_wrap_flags", dw_rd, 2); chk("ovf_sat_flags", ds_rd, 2);
        chk("ovf_live", ds_ovf, 7'b0000010);

        // snapshot and clear in the same cycle
        clr();
        repeat (50) step();
        snapshot_i = 1'b1; clear_i = 1'b1;
        step();
        snapshot_i = 1'b0; clear_i = 1'b0; valid_i = 2'b00;
        chk("coll_state", dw_st, 0);
        chk("coll_ovf", dw_ovf, 0);
        rd(0); chk("coll_shadow_cyc", dw_rd, 50);
        rd(1); chk("coll_shadow_instr", dw_rd, 100);
        snap();
        rd(0); chk("coll_live_cyc", dw_rd, 0);
        valid_i = 2'b11;
        repeat (5) step();
        snap();
        valid_i = 2'b00;
        clr();
        rd(0); chk("clr_shadow", dw_rd, 0);

        // reset in the middle of a run
        valid_i = 2'b11;
        repeat (10) step();
        snap();
        rd(0); chk("mid_pre", dw_rd, 10);
        repeat (8) step();
        reset = 1'b1;
        step();
        chk("mid_state", dw_st, 0);
        chk("mid_done", dw_done, 0);
        chk("mid_ovf", dw_ovf, 0);
        chk("mid_rd", dw_rd, 0);
        reset = 1'b0; valid_i = 2'b00;
        snap();
        rd(0); chk("mid_live_cyc", dw_rd, 0);
        chk("mid_state_idle", dw_st, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_perf_monitor.md
# ucsbece154b_perf_monitor

Synthesizable performance monitor for the superscalar pipeline that counts the same events the top-level bench measures: cycles, issued instructions, branches, jumps, their mispredictions, and stall cycles. It is generalised over issue width, counter width and overflow mode. It adds a run/done state machine with idle-based program-end detection, an atomic snapshot, and a registered read port. It sits beside the datapath, sampling per-lane Execute-stage event strobes, and is read by the bench or a debug unit.

## Interface
- LANES, 2, number of issue lanes sampled per cycle (1..8)
- CNT_W, 32, width of every event counter (8..64)
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters hold at all-ones
- IDLE_LIMIT, 16, consecutive cycles with no valid lane that end the run (2..255)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- valid_i  in  LANES  lane k holds a real instruction in Execute this cycle
- is_branch_i  in  LANES  lane k is a conditional branch
- is_jump_i  in  LANES  lane k is jal/jalr
- mispredict_i  in  LANES  lane k redirected fetch
- stall_i  in  1  pipeline stalled this cycle
- done_i  in  1  external end-of-program strobe
- clear_i  in  1  zero all counters and flags, return to IDLE
- snapshot_i  in  1  copy live counters into shadow bank
- rd_sel_i  in  3  shadow counter index
- rd_data_o  out  CNT_W  selected shadow value, registered
- ovf_o  out  7  sticky per-counter overflow flags
- state_o  out  2  IDLE=0, RUN=1, DONE=2
- done_o  out  1  high while in DONE

## Operation
- Counter indices: 0 CYCLES, 1 INSTR, 2 BRANCH, 3 BR_MISS, 4 JUMP, 5 J_MISS, 6 STALL. Index 7 reads ovf_o zero-extended.
- Per-lane qualification:
  - br_k = valid_k & is_branch_k
  - jmp_k = valid_k & is_jump_k & ~is_branch_k (branch wins)
  - Mispredict counts only when br_k or jmp_k is set.
- Increments per RUN cycle:
  - CYCLES +1
  - INSTR +popcount(valid)
  - BRANCH +popcount(br)
  - BR_MISS +popcount(br & mispredict)
  - JUMP +popcount(jmp)
  - J_MISS +popcount(jmp & mispredict)
  - STALL +stall_i
- Increment width is clog2(LANES+1) bits, zero-extended to CNT_W.
- Overflow: when the sum exceeds 2^CNT_W-1, wrap mode stores the sum modulo 2^CNT_W and saturate mode stores all-ones. Either way the sticky ovf bit is set and stays set until clear or reset.
- FSM:
  - IDLE -> RUN on the first cycle with any valid bit set; that cycle is counted.
  - RUN -> DONE when done_i is high, or when the idle run counter reaches IDLE_LIMIT. The transition cycle is counted.
  - DONE holds and counts nothing. Only clear_i or reset leave DONE.
  - In IDLE and DONE, no counter changes.
- Idle run counter: 8 bits. Increments on RUN cycles with valid == 0; zeroed on any valid bit.
- Priority: reset > clear_i > counting. clear_i zeroes counters, ovf, the idle run counter and the shadow bank, and sets state to IDLE.
- Snapshot captures the live register values before this cycle's update. With snapshot_i and clear_i in the same cycle, the shadow bank receives the pre-clear values.

## Timing
- Reset values: all counters, shadows, ovf_o and rd_data_o are 0; state_o = IDLE; done_o = 0.
- Counter update is visible in live registers one cycle after the event.
- The shadow bank updates on the edge where snapshot_i is sampled.
- rd_data_o = shadow[rd_sel_i] one cycle after rd_sel_i is sampled.
- done_o asserts the cycle after the RUN->DONE condition is sampled.
- If reset is asserted mid-run, all state returns to reset values on the next edge. No partial counts survive.

## Structure
- Shared package ucsbece154b_perf_pkg holds:
  - counter index localparams (CNT_CYCLES .. CNT_STALL, RD_OVF = 7)
  - NUM_CNT = 7
  - FSM state encoding
- Sub-module ucsbece154b_perf_ctr is instantiated 7 times. It holds one CNT_W counter, the increment input, the SATURATE mode, and the sticky overflow bit.
- Popcount, FSM, idle run counter, shadow bank and read mux live in the top module.

## Test plan
- Basic run: reset, then 10 cycles of valid=2'b11 with no events -> after snapshot, CYCLES=10, INSTR=20, ovf=0, state=RUN.
- Branch stats: lane0 branch with mispredict, lane1 jump without mispredict, 4 cycles -> BRANCH=4, BR_MISS=4, JUMP=4, J_MISS=0. Also drive is_branch and is_jump on the same lane -> counted only as BRANCH.
- Idle end: IDLE_LIMIT=4, 3 valid cycles then valid=0 -> DONE after 4 idle cycles, CYCLES=7. Further valid cycles leave all counters unchanged.
- Overflow: CNT_W=8, LANES=2, 130 dual-issue cycles:
  - SATURATE=0 -> INSTR=260 mod 256=4, ovf[1]=1
  - SATURATE=1 -> INSTR=255, ovf[1]=1
- Snapshot/clear collision: with CYCLES=50, assert snapshot_i and clear_i together -> shadow CYCLES=50, live CYCLES=0, state=IDLE; rd_sel=0 returns 50 one cycle later.
- Reset mid-run: assert reset at cycle 20 of RUN -> the next edge gives all outputs 0 and state IDLE.
